// File: rtl/tree_pkg.sv
// Constants and types shared by the tree reduction stage and its downstream consumers.
package tree_pkg;

    localparam int TREE_LATENCY = 3;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/tree_result_fifo.sv
// First-word-fall-through FIFO for packed tree results; the head entry is visible while non-empty.
module tree_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == LW'(0));
    assign o_full    = (r_count == LW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_level   = r_count;
    assign o_data    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

    // Storage array; contents are only observed through the occupancy-gated head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {LW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tree_collector.sv
// Qualifies tree results with a delayed valid, packs them LSB-first into bytes and buffers
// them for a valid/ready sink, with a running ones count and a sticky overflow flag.
module tree_collector
    import tree_pkg::*;
#(
    parameter int LATENCY = TREE_LATENCY,
    parameter int DEPTH   = 4,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [LW-1:0] level,
    output logic [15:0]   ones_count,
    output logic          overflow,
    input  logic          clr_overflow
);

    logic [LATENCY-1:0] r_vld;
    logic [2:0]         r_bit_cnt;
    byte_t              r_shift;
    logic [15:0]        r_ones;
    logic               r_overflow;
    logic               w_qual;
    logic               w_byte_done;
    byte_t              w_byte;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;

    assign w_qual      = r_vld[LATENCY-1];
    assign w_byte_done = w_qual & (r_bit_cnt == 3'd7);
    assign w_byte      = {b, r_shift[6:0]};
    assign w_drop      = w_byte_done & w_full & ~out_ready;

    // Valid qualifier tracks each word through the tree's fixed pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= {LATENCY{1'b0}};
        end else begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Packer and ones counter; b is garbage unless qualified, so it is never looked at otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_ones    <= 16'd0;
        end else if (w_qual) begin
            r_shift[r_bit_cnt] <= b;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (b) begin
                r_ones <= r_ones + 16'd1;
            end
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    tree_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_byte_done),
        .i_data  (w_byte),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign out_valid  = ~w_empty;
    assign ones_count = r_ones;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_tree_collector.sv
// Directed bench for tree_collector: a 3-stage model of tree delays each word's result bit.
module tb_tree_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic [15:0] ones_count;
    logic        overflow;
    logic        clr_overflow;

    int          tests = 0;
    int          fails = 0;
    int          exp_ones = 0;
    logic [2:0]  pv;
    logic [2:0]  pb;

    tree_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .ones_count   (ones_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive word qualifier, present the result of the word from 3 cycles ago.
    task automatic step(input logic iv, input logic wb, input logic rdy);
        in_valid  = iv;
        out_ready = rdy;
        b = pv[2] ? pb[2] : 1'($urandom);
        if (pv[2] && pb[2]) exp_ones++;
        pv = {pv[1:0], iv};
        pb = {pb[1:0], wb};
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic rdy);
        for (int i = 0; i < 8; i++) step(1'b1, v[i], rdy);
    endtask

    task automatic flush(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] exp_q [4];

        rst_n = 1'b0; in_valid = 1'b0; b = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
        pv = 3'b000; pb = 3'b000;
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ones", 32'(ones_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Back-to-back byte: edges 0..7 carry the words, byte lands on edge 10.
        send_byte(8'h8D, 1'b0);
        flush(2, 1'b0);
        check("t1_not_early", 32'(out_valid), 32'd0);
        flush(1, 1'b0);
        check("t1_valid_at_10", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h8D);
        check("t1_level", 32'(level), 32'd1);
        check("t1_ones", 32'(ones_count), 32'd4);
        flush(1, 1'b1);
        check("t1_popped", 32'(out_valid), 32'd0);
        check("t1_data_empty", 32'(out_data), 32'd0);

        // Same byte with random gaps and garbage b while unqualified.
        v = 8'h8D;
        for (int i = 0; i < 8; i++) begin
            flush(int'($urandom_range(0, 3)), 1'b0);
            step(1'b1, v[i], 1'b0);
        end
        flush(3, 1'b0);
        check("t2_data", 32'(out_data), 32'h8D);
        check("t2_level", 32'(level), 32'd1);
        check("t2_ones", 32'(ones_count), 32'd8);
        flush(1, 1'b1);

        // Five bytes into a 4-deep FIFO with no sink.
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0); send_byte(8'h55, 1'b0);
        flush(3, 1'b0);
        check("t3_level_full", 32'(level), 32'd4);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_ones", 32'(ones_count), exp_ones & 32'hFFFF);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) begin
            check("t3_drain", 32'(out_data), 32'(exp_q[k]));
            flush(1, 1'b1);
        end
        check("t3_empty", 32'(out_valid), 32'd0);
        check("t3_ovf_kept", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        flush(1, 1'b0);
        clr_overflow = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO, push and pop on the same edge.
        send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b0); send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0); send_byte(8'hA5, 1'b0);
        flush(2, 1'b0);
        check("t4_full_before", 32'(level), 32'd4);
        flush(1, 1'b1);
        check("t4_level", 32'(level), 32'd4);
        check("t4_no_ovf", 32'(overflow), 32'd0);
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int k = 0; k < 4; k++) begin
            check("t4_drain", 32'(out_data), 32'(exp_q[k]));
            flush(1, 1'b1);
        end
        check("t4_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-byte with two bytes buffered.
        send_byte(8'hB1, 1'b0); send_byte(8'hB2, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        flush(3, 1'b0);
        check("t5_level_pre", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_data", 32'(out_data), 32'd0);
        check("t5_async_level", 32'(level), 32'd0);
        check("t5_async_ones", 32'(ones_count), 32'd0);
        pv = 3'b000; pb = 3'b000; exp_ones = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_byte(8'hC3, 1'b0);
        flush(3, 1'b0);
        check("t5_clean_byte", 32'(out_data), 32'hC3);
        check("t5_level", 32'(level), 32'd1);
        check("t5_ones", 32'(ones_count), 32'd4);

        // Ones counter wrap.
        rst_n = 1'b0;
        pv = 3'b000; pb = 3'b000; exp_ones = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) step(1'b1, 1'b1, 1'b1);
        flush(3, 1'b1);
        check("t6_ones_wrap", 32'(ones_count), 32'd1);
        check("t6_no_ovf", 32'(overflow), 32'd0);
        check("t6_level", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
